sap1_memory_unit: RTL

- Memory stage of the SAP-1 datapath: memory address register (MAR) plus a DEPTH x DATA_W RAM.
- Sits directly downstream of the controller. Consumes the controller's MEM_LOAD (bit 8) and MEM_EN (bit 7) control-word bits, and drives RAM data onto the shared bus.
- Adds a host programming port (valid/ready) and a hardware clear sweep, so programs can be loaded while the CPU is held.

---
 rtl/sap1_memory_unit_pkg.sv | 33 +++
 rtl/sap1_memory_unit_if.sv | 31 +++
 rtl/sap1_memory_unit_ram.sv | 22 ++
 rtl/sap1_memory_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/sap1_memory_unit_pkg.sv
// Shared SAP-1 definitions: widths, control-word bit positions, opcodes and
// the memory-stage FSM encoding.
package sap1_memory_unit_pkg;

    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;

    // Control-word bit indices, HLT at the top down to ADDER_EN at bit 0.
    localparam int CW_HLT      = 11;
    localparam int CW_PC_INC   = 10;
    localparam int CW_PC_EN    = 9;
    localparam int CW_MEM_LOAD = 8;
    localparam int CW_MEM_EN   = 7;
    localparam int CW_IR_LOAD  = 6;
    localparam int CW_IR_EN    = 5;
    localparam int CW_A_LOAD   = 4;
    localparam int CW_A_EN     = 3;
    localparam int CW_SUB      = 2;
    localparam int CW_B_LOAD   = 1;
    localparam int CW_ADDER_EN = 0;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1,
        ST_CLEAR = 2'd2
    } mem_state_e;

endpackage

// File: rtl/sap1_memory_unit_if.sv
// Controller/host-facing signal bundle of the SAP-1 memory stage.
interface sap1_memory_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] bus_in;
    logic              mem_load;
    logic              mem_en;
    logic [DATA_W-1:0] mem_out;
    logic              prog_mode;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              clear_req;
    logic              busy;
    logic              clear_done;
    logic              err;

    modport master (
        output bus_in, mem_load, mem_en, prog_mode, prog_valid, prog_addr,
               prog_data, clear_req,
        input  mem_out, prog_ready, busy, clear_done, err
    );

    modport slave (
        input  bus_in, mem_load, mem_en, prog_mode, prog_valid, prog_addr,
               prog_data, clear_req,
        output mem_out, prog_ready, busy, clear_done, err
    );
endinterface

// File: rtl/sap1_memory_unit_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sap1_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sap1_memory_unit.sv
// SAP-1 memory stage: MAR + RAM on the CPU side, plus a host programming port
// and a hardware clear sweep that own the RAM write port while the CPU is held.
module sap1_memory_unit
    import sap1_memory_unit_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DATA_W = SAP1_DATA_W,
    parameter int DEPTH  = 16          // must equal 2**ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    sap1_memory_unit_if.slave  bus
);
    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clear_done_q, clear_done_d;
    logic              err_q, err_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              sweep_last;
    logic              unused_bus_hi;

    assign sweep_last    = (cnt_q == ADDR_W'(DEPTH - 1));
    assign unused_bus_hi = ^bus.bus_in[DATA_W-1:ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            mar_q        <= '0;
            cnt_q        <= '0;
            clear_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mar_q        <= mar_d;
            cnt_q        <= cnt_d;
            clear_done_q <= clear_done_d;
            err_q        <= err_d;
        end
    end

    // clear_req wins over prog_mode; a request during CLEAR is simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.clear_req)      state_d = ST_CLEAR;
                else if (bus.prog_mode) state_d = ST_PROG;
            end
            ST_PROG: begin
                if (bus.clear_req)       state_d = ST_CLEAR;
                else if (!bus.prog_mode) state_d = ST_RUN;
            end
            ST_CLEAR: begin
                if (sweep_last) state_d = bus.prog_mode ? ST_PROG : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mar_d          = mar_q;
        cnt_d          = '0;
        clear_done_d   = 1'b0;
        err_d          = err_q;
        we             = 1'b0;
        waddr          = bus.prog_addr;
        wdata          = bus.prog_data;
        bus.prog_ready = 1'b0;
        bus.mem_out    = '0;
        bus.busy       = (state_q != ST_RUN);
        bus.clear_done = clear_done_q;
        bus.err        = err_q;

        if (state_q == ST_RUN) begin
            if (bus.mem_load) mar_d = bus.bus_in[ADDR_W-1:0];
            if (bus.mem_en)   bus.mem_out = rdata;
        end else if (bus.mem_load || bus.mem_en) begin
            err_d = 1'b1;
        end

        if (state_q == ST_PROG) begin
            bus.prog_ready = bus.prog_mode;
            we             = bus.prog_valid && bus.prog_mode;
        end

        if (state_q == ST_CLEAR) begin
            we           = 1'b1;
            waddr        = cnt_q;
            wdata        = '0;
            cnt_d        = cnt_q + 1'b1;   // wraps to 0 after DEPTH-1
            clear_done_d = sweep_last;
        end
    end

    sap1_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (mar_q),
        .rdata_o (rdata)
    );
endmodule
